// File: rtl/tinynpu_pkg.sv
// ============================================================================
// Module      : tinynpu_pkg
// Description : Shared types and helpers for the output-stationary GEMM
//               engine: engine FSM state encoding and counter width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tinynpu_pkg;

  // Engine command FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DRAIN = 2'd3
  } engine_state_t;

  // Default geometry shared by the engine and its neighbours.
  localparam int unsigned DEF_ROWS       = 4;
  localparam int unsigned DEF_COLS       = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 64;
  localparam int unsigned DEF_K_MAX      = 256;

  // Width of a counter indexing n values; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/os_mac_cell.sv
// ============================================================================
// Module      : os_mac_cell
// Description : One processing element of the output-stationary grid.
//               Registers the incoming A (left) and B (top) operands for the
//               next cell and accumulates their signed product.
// Ports       : clk, rst_n        clock, async active-low reset
//               adv_i             grid advance; everything holds when low
//               clr_i             zero the accumulator (command accept)
//               a_i / a_o         A operand in from left, out to right
//               b_i / b_o         B operand in from top, out to bottom
//               acc_o             accumulator value
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module os_mac_cell #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  adv_i,
  input  logic                  clr_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [ACC_WIDTH-1:0]  acc_o
);

  logic [DATA_WIDTH-1:0]          a_q;
  logic [DATA_WIDTH-1:0]          b_q;
  logic [ACC_WIDTH-1:0]           acc_q;
  logic [ACC_WIDTH-1:0]           acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod;

  // Full-precision signed product, sign-extended into the accumulator width;
  // the sum wraps modulo 2^ACC_WIDTH.
  assign prod  = $signed(a_i) * $signed(b_i);
  assign acc_d = acc_q + ACC_WIDTH'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (adv_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_d;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/os_systolic_engine.sv
// ============================================================================
// Module      : os_systolic_engine
// Description : Output-stationary ROWS x COLS GEMM engine. Takes unskewed A
//               column / B row vectors, skews them internally, accumulates
//               C[r][c] (+)= sum_k A[r][k]*B[k][c] and drains C one row per
//               output handshake.
// Ports       : clk, rst_n                  clock, async active-low reset
//               cmd_valid/cmd_ready         command handshake (ready = idle)
//               cmd_k, cmd_accumulate       reduction length, keep-acc flag
//               in_valid/in_ready           A/B vector pair handshake
//               in_a, in_b                  packed A[.][k] and B[k][.]
//               out_valid/out_ready         result row handshake
//               out_data, out_row, out_last result row, its index, last flag
//               busy                        engine not idle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module os_systolic_engine
  import tinynpu_pkg::*;
#(
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLS       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = 64,
  parameter int unsigned K_MAX      = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [$clog2(K_MAX+1)-1:0]   cmd_k,
  input  logic                         cmd_accumulate,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ROWS*DATA_WIDTH-1:0]   in_a,
  input  logic [COLS*DATA_WIDTH-1:0]   in_b,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [COLS*ACC_WIDTH-1:0]    out_data,
  output logic [cnt_width(ROWS)-1:0]   out_row,
  output logic                         out_last,
  output logic                         busy
);

  localparam int unsigned KW        = $clog2(K_MAX + 1);
  localparam int unsigned RW        = cnt_width(ROWS);
  localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;
  localparam int unsigned FW        = cnt_width(FLUSH_LEN);

  engine_state_t   state_q;
  logic [KW-1:0]   k_q;
  logic [KW-1:0]   kcnt_q;
  logic [FW-1:0]   flush_q;
  logic [RW-1:0]   row_q;

  logic cmd_fire;
  logic in_fire;
  logic adv;
  logic clr;

  assign cmd_fire = cmd_valid && (state_q == IDLE);
  assign in_fire  = in_valid && (state_q == FEED);
  // The grid only moves on an accepted vector or a flush cycle, so input
  // bubbles freeze every skew, operand and accumulator register.
  assign adv      = in_fire || (state_q == FLUSH);
  assign clr      = cmd_fire && !cmd_accumulate;

  // --------------------------------------------------------------------------
  // Command FSM and counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      kcnt_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            k_q     <= cmd_k;
            kcnt_q  <= '0;
            flush_q <= '0;
            row_q   <= '0;
            state_q <= (cmd_k == '0) ? DRAIN : FEED;
          end
        end
        FEED: begin
          if (in_fire) begin
            if (kcnt_q == k_q - KW'(1)) begin
              kcnt_q  <= '0;
              flush_q <= '0;
              state_q <= FLUSH;
            end else begin
              kcnt_q <= kcnt_q + KW'(1);
            end
          end
        end
        FLUSH: begin
          if (flush_q == FW'(FLUSH_LEN - 1)) begin
            flush_q <= '0;
            state_q <= DRAIN;
          end else begin
            flush_q <= flush_q + FW'(1);
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (row_q == RW'(ROWS - 1)) begin
              row_q   <= '0;
              state_q <= IDLE;
            end else begin
              row_q <= row_q + RW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign in_ready  = (state_q == FEED);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q != IDLE);
  assign out_row   = row_q;
  assign out_last  = out_valid && (row_q == RW'(ROWS - 1));

  // --------------------------------------------------------------------------
  // Operand skew: row r of A and column c of B are delayed r / c advances so
  // element k meets in cell [r][c] on advance k+r+c. Zeros are injected
  // outside FEED, which also leaves the delay lines empty after FLUSH.
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] a_w [ROWS][COLS+1];
  logic [DATA_WIDTH-1:0] b_w [ROWS+1][COLS];
  logic [ACC_WIDTH-1:0]  acc_w [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
    logic [DATA_WIDTH-1:0] a_inj;
    assign a_inj = (state_q == FEED) ? in_a[r*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (r == 0) begin : g_direct
      assign a_w[r][0] = a_inj;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dl_q [r];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < r; i++) dl_q[i] <= '0;
        end else if (adv) begin
          dl_q[0] <= a_inj;
          for (int i = 1; i < r; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign a_w[r][0] = dl_q[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_b_skew
    logic [DATA_WIDTH-1:0] b_inj;
    assign b_inj = (state_q == FEED) ? in_b[c*DATA_WIDTH +: DATA_WIDTH] : '0;
    if (c == 0) begin : g_direct
      assign b_w[0][c] = b_inj;
    end else begin : g_delay
      logic [DATA_WIDTH-1:0] dl_q [c];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < c; i++) dl_q[i] <= '0;
        end else if (adv) begin
          dl_q[0] <= b_inj;
          for (int i = 1; i < c; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign b_w[0][c] = dl_q[c-1];
    end
  end

  // --------------------------------------------------------------------------
  // MAC grid: A flows right, B flows down.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      os_mac_cell #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
      ) u_cell (
        .clk   (clk),
        .rst_n (rst_n),
        .adv_i (adv),
        .clr_i (clr),
        .a_i   (a_w[r][c]),
        .b_i   (b_w[r][c]),
        .a_o   (a_w[r][c+1]),
        .b_o   (b_w[r+1][c]),
        .acc_o (acc_w[r][c])
      );
    end
  end

  // --------------------------------------------------------------------------
  // Drain mux: selected row is a pure function of row_q, so it stays stable
  // under back-pressure; forced to zero outside DRAIN.
  // --------------------------------------------------------------------------
  always_comb begin
    out_data = '0;
    if (state_q == DRAIN) begin
      for (int c = 0; c < COLS; c++) begin
        out_data[c*ACC_WIDTH +: ACC_WIDTH] = acc_w[row_q][c];
      end
    end
  end

  a_cmd_k_range : assert property (@(posedge clk) disable iff (!rst_n)
    (cmd_valid && cmd_ready) |-> (cmd_k <= KW'(K_MAX)));

endmodule

`default_nettype wire

// File: tb/tb_os_systolic_engine.sv
// ============================================================================
// Module      : tb_os_systolic_engine
// Description : Self-checking bench for os_systolic_engine (4x4, 16/64 bit).
//               Expected results come from a plain matrix-multiply model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_os_systolic_engine;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int AW   = 64;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int TBK  = 16;

  logic                 clk;
  logic                 rst_n;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [KW-1:0]        cmd_k;
  logic                 cmd_accumulate;
  logic                 in_valid;
  logic                 in_ready;
  logic [ROWS*DW-1:0]   in_a;
  logic [COLS*DW-1:0]   in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [COLS*AW-1:0]   out_data;
  logic [1:0]           out_row;
  logic                 out_last;
  logic                 busy;

  os_systolic_engine #(
    .ROWS(ROWS), .COLS(COLS), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .K_MAX(KMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_k(cmd_k),
    .cmd_accumulate(cmd_accumulate),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [DW-1:0] a_mem [ROWS][TBK];
  logic signed [DW-1:0] b_mem [TBK][COLS];
  longint               exp_c [ROWS][COLS];
  logic [AW-1:0]        got_data [ROWS][COLS];
  int                   got_row  [ROWS];
  bit                   got_last [ROWS];
  int                   flush_cycles;
  bit                   feed_seen, timed_out, stall_unstable, post_idle;

  // ---------------- reference model: C = (acc ? C : 0) + A*B ----------------
  function automatic void model(input int k, input bit acc);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        if (!acc) exp_c[r][c] = 0;
        for (int i = 0; i < k; i++)
          exp_c[r][c] += longint'(a_mem[r][i]) * longint'(b_mem[i][c]);
      end
  endfunction

  function automatic logic [ROWS*DW-1:0] pack_a(input int k);
    logic [ROWS*DW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = a_mem[r][k];
    return v;
  endfunction

  function automatic logic [COLS*DW-1:0] pack_b(input int k);
    logic [COLS*DW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*DW +: DW] = b_mem[k][c];
    return v;
  endfunction

  task automatic fill_identity();
    for (int k = 0; k < TBK; k++) begin
      for (int r = 0; r < ROWS; r++) a_mem[r][k] = (r == k) ? 16'sd1 : 16'sd0;
      for (int c = 0; c < COLS; c++) b_mem[k][c] = DW'(k * COLS + c + 1);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < TBK; k++) begin
      for (int r = 0; r < ROWS; r++) a_mem[r][k] = DW'($urandom);
      for (int c = 0; c < COLS; c++) b_mem[k][c] = DW'($urandom);
    end
  endtask

  // Issue one command, feed K vectors, count flush cycles, drain all rows.
  task automatic run_cmd(input int k, input bit acc, input bit bubbles, input bit stall);
    int  t, idx, received, stall_left;
    bit  bub, hs, have_ref;
    logic [COLS*AW-1:0] ref_data;
    logic [1:0]         ref_row;
    timed_out = 0; feed_seen = 0; stall_unstable = 0; flush_cycles = 0;
    have_ref = 0; ref_data = '0; ref_row = '0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_k = KW'(k); cmd_accumulate = acc;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (!cmd_ready) timed_out = 1;
    @(posedge clk); #1 cmd_valid = 1'b0;
    idx = 0; t = 0;
    while (idx < k && t < 1000) begin
      @(negedge clk);
      bub = bubbles && ($urandom_range(0, 1) == 0);
      in_valid = !bub;
      in_a = bub ? {$urandom, $urandom} : pack_a(idx);
      in_b = bub ? {$urandom, $urandom} : pack_b(idx);
      if (in_ready) feed_seen = 1;
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) idx++;
      t++;
    end
    if (idx < k) timed_out = 1;
    @(negedge clk);
    // Junk vectors outside FEED must be ignored.
    in_valid = bubbles; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    t = 0;
    while (!out_valid && t < 200) begin
      if (in_ready) feed_seen = 1;
      flush_cycles++;
      @(negedge clk);
      t++;
    end
    if (in_ready) feed_seen = 1;
    in_valid = 1'b0;
    received = 0; stall_left = stall ? 5 : 0; t = 0;
    while (received < ROWS && t < 200) begin
      if (out_valid) begin
        if (stall && out_row == 2'd1 && stall_left > 0) begin
          out_ready = 1'b0;
          if (!have_ref) begin ref_data = out_data; ref_row = out_row; have_ref = 1; end
          else if (out_data !== ref_data || out_row !== ref_row) stall_unstable = 1;
          stall_left--;
        end else begin
          out_ready = 1'b1;
          got_row[received]  = int'(out_row);
          got_last[received] = out_last;
          for (int c = 0; c < COLS; c++) got_data[received][c] = out_data[c*AW +: AW];
          received++;
        end
      end else begin
        out_ready = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (received < ROWS) timed_out = 1;
    post_idle = cmd_ready && !busy && !out_valid;
  endtask

  // ------------------------------ tests ------------------------------------
  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got cmd_ready=%b in_ready=%b out_valid=%b busy=%b, expected 1 0 0 0",
               cmd_ready, in_ready, out_valid, busy);
    end
    n_tests++;
    if (out_row !== 2'd0 || out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL reset_out: got out_row=%0d out_last=%b out_data=%h, expected 0 0 0",
               out_row, out_last, out_data);
    end
  endtask

  task automatic test_identity();
    fill_identity();
    run_cmd(4, 0, 0, 0);
    model(4, 0);
    n_tests++;
    if (timed_out || !post_idle) begin n_fail++;
      $display("FAIL identity_hs: got timed_out=%b post_idle=%b, expected 0 1", timed_out, post_idle); end
    n_tests++;
    if (flush_cycles != ROWS + COLS - 1) begin n_fail++;
      $display("FAIL identity_flush: got %0d cycles, expected %0d", flush_cycles, ROWS + COLS - 1); end
    for (int i = 0; i < ROWS; i++) begin
      n_tests++;
      if (got_row[i] != i || got_last[i] !== (i == ROWS - 1)) begin n_fail++;
        $display("FAIL identity_row%0d: got row=%0d last=%b, expected row=%0d last=%b",
                 i, got_row[i], got_last[i], i, (i == ROWS - 1)); end
      for (int c = 0; c < COLS; c++) begin
        n_tests++;
        if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
          $display("FAIL identity_C[%0d][%0d]: got %h, expected %h", i, c, got_data[i][c], exp_c[i][c]); end
      end
    end
  endtask

  task automatic test_negative();
    for (int k = 0; k < TBK; k++) begin
      for (int r = 0; r < ROWS; r++) a_mem[r][k] = -16'sd1;
      for (int c = 0; c < COLS; c++) b_mem[k][c] = 16'sd2;
    end
    run_cmd(8, 0, 0, 0);
    model(8, 0);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL negative_hs: got timed_out=1, expected 0"); end
    n_tests++;
    if (got_data[0][0] !== 64'hFFFF_FFFF_FFFF_FFF0) begin n_fail++;
      $display("FAIL negative_const: got %h, expected fffffffffffffff0", got_data[0][0]); end
    for (int i = 0; i < ROWS; i++)
      for (int c = 0; c < COLS; c++) begin
        n_tests++;
        if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
          $display("FAIL negative_C[%0d][%0d]: got %h, expected %h", i, c, got_data[i][c], exp_c[i][c]); end
      end
  endtask

  task automatic test_bubbles();
    fill_identity();
    run_cmd(4, 0, 1, 0);
    model(4, 0);
    n_tests++;
    if (timed_out || flush_cycles != ROWS + COLS - 1) begin n_fail++;
      $display("FAIL bubbles_flush: got timed_out=%b flush=%0d, expected 0 %0d",
               timed_out, flush_cycles, ROWS + COLS - 1); end
    for (int i = 0; i < ROWS; i++)
      for (int c = 0; c < COLS; c++) begin
        n_tests++;
        if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
          $display("FAIL bubbles_C[%0d][%0d]: got %h, expected %h", i, c, got_data[i][c], exp_c[i][c]); end
      end
  endtask

  task automatic test_accumulate();
    fill_identity();
    run_cmd(4, 0, 0, 0);
    model(4, 0);
    run_cmd(4, 1, 0, 0);
    model(4, 1);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL accum_hs: got timed_out=1, expected 0"); end
    for (int i = 0; i < ROWS; i++)
      for (int c = 0; c < COLS; c++) begin
        n_tests++;
        if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
          $display("FAIL accum_C[%0d][%0d]: got %h, expected %h", i, c, got_data[i][c], exp_c[i][c]); end
      end
    run_cmd(0, 0, 0, 0);
    model(0, 0);
    n_tests++;
    if (timed_out || feed_seen || flush_cycles != 0) begin n_fail++;
      $display("FAIL k0_path: got timed_out=%b feed_seen=%b flush=%0d, expected 0 0 0",
               timed_out, feed_seen, flush_cycles); end
    for (int i = 0; i < ROWS; i++) begin
      n_tests++;
      if (got_row[i] != i || got_data[i][0] !== AW'(exp_c[i][0]) || got_data[i][COLS-1] !== AW'(exp_c[i][COLS-1])) begin
        n_fail++;
        $display("FAIL k0_row%0d: got row=%0d C0=%h C3=%h, expected row=%0d zeros",
                 i, got_row[i], got_data[i][0], got_data[i][COLS-1], i); end
    end
  endtask

  task automatic test_backpressure();
    fill_identity();
    run_cmd(4, 0, 0, 1);
    model(4, 0);
    n_tests++;
    if (timed_out || stall_unstable) begin n_fail++;
      $display("FAIL stall_stable: got timed_out=%b unstable=%b, expected 0 0", timed_out, stall_unstable); end
    for (int i = 0; i < ROWS; i++) begin
      n_tests++;
      if (got_row[i] != i || got_last[i] !== (i == ROWS - 1)) begin n_fail++;
        $display("FAIL stall_row%0d: got row=%0d last=%b, expected %0d %b",
                 i, got_row[i], got_last[i], i, (i == ROWS - 1)); end
      for (int c = 0; c < COLS; c++) begin
        n_tests++;
        if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
          $display("FAIL stall_C[%0d][%0d]: got %h, expected %h", i, c, got_data[i][c], exp_c[i][c]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_identity();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_k = KW'(4); cmd_accumulate = 1'b0;
    @(posedge clk); #1 cmd_valid = 1'b0;
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = pack_a(j); in_b = pack_b(j);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (cmd_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 ||
        out_row !== 2'd0 || out_last !== 1'b0 || out_data !== '0) begin
      n_fail++;
      $display("FAIL midreset_outs: got cmd_ready=%b in_ready=%b out_valid=%b busy=%b row=%0d last=%b, expected 1 0 0 0 0 0",
               cmd_ready, in_ready, out_valid, busy, out_row, out_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Accumulating onto post-reset state must still give exactly B.
    run_cmd(4, 1, 0, 0);
    model(4, 0);
    n_tests++;
    if (timed_out) begin n_fail++; $display("FAIL midreset_hs: got timed_out=1, expected 0"); end
    for (int i = 0; i < ROWS; i++)
      for (int c = 0; c < COLS; c++) begin
        n_tests++;
        if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
          $display("FAIL midreset_C[%0d][%0d]: got %h, expected %h", i, c, got_data[i][c], exp_c[i][c]); end
      end
  endtask

  task automatic test_random();
    int  k;
    bit  acc;
    for (int it = 0; it < 4; it++) begin
      fill_random();
      k   = $urandom_range(1, 12);
      acc = ($urandom_range(0, 1) == 1);
      run_cmd(k, acc, 1, 0);
      model(k, acc);
      n_tests++;
      if (timed_out || flush_cycles != ROWS + COLS - 1) begin n_fail++;
        $display("FAIL random%0d_flow: got timed_out=%b flush=%0d, expected 0 %0d",
                 it, timed_out, flush_cycles, ROWS + COLS - 1); end
      for (int i = 0; i < ROWS; i++)
        for (int c = 0; c < COLS; c++) begin
          n_tests++;
          if (got_data[i][c] !== AW'(exp_c[i][c])) begin n_fail++;
            $display("FAIL random%0d_C[%0d][%0d]: got %h, expected %h (k=%0d acc=%b)",
                     it, i, c, got_data[i][c], exp_c[i][c], k, acc); end
        end
    end
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_k = '0; cmd_accumulate = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) exp_c[r][c] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_identity();
    test_negative();
    test_bubbles();
    test_accumulate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
